// File: rtl/sseg_capture_if.sv
// Seven-segment readback bus: the sampled display lines plus the reconstructed digit outputs.
interface sseg_capture_if #(
    parameter int unsigned NDIG = 4
);
    logic [6:0]        SSeg;
    logic [NDIG-1:0]   an;
    logic [4*NDIG-1:0] bcd;
    logic [NDIG-1:0]   dig_valid;
    logic [NDIG-1:0]   dig_err;
    logic              upd;
    logic [2:0]        upd_idx;

    // The display side drives segments and select; it observes the captured digits.
    modport master (
        output SSeg,
        output an,
        input  bcd,
        input  dig_valid,
        input  dig_err,
        input  upd,
        input  upd_idx
    );

    // The capture block samples segments and select; it produces the captured digits.
    modport slave (
        input  SSeg,
        input  an,
        output bcd,
        output dig_valid,
        output dig_err,
        output upd,
        output upd_idx
    );
endinterface

// File: rtl/sseg_capture.sv
// Seven-segment readback decoder: filters each (select, segment) dwell for stability,
// decodes the pattern of the selected digit and records it with valid/error flags.
module sseg_capture #(
    parameter int unsigned NDIG   = 4,
    parameter int unsigned STABLE = 3
) (
    input  logic          clk,
    input  logic          rst,
    sseg_capture_if.slave bus
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned IDX_W = 3;
    localparam int unsigned BCD_W = 4 * NDIG;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_HELD  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        PAT_DIGIT   = 2'd0,
        PAT_BLANK   = 2'd1,
        PAT_ILLEGAL = 2'd2
    } pat_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NDIG-1:0]    prev_an_q;
    logic [6:0]         prev_seg_q;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [NDIG-1:0]    dig_valid_q, dig_valid_d;
    logic [NDIG-1:0]    dig_err_q, dig_err_d;
    logic               upd_q, upd_d;
    logic [IDX_W-1:0]   upd_idx_q, upd_idx_d;

    logic               an_onehot;
    logic               pair_same;
    logic [IDX_W-1:0]   an_idx;
    pat_e               pat_kind;
    logic [3:0]         pat_val;
    logic               accept;
    state_e             restart_state;
    logic [CNT_W-1:0]   restart_cnt;

    // A select is only meaningful when exactly one digit line is high.
    assign an_onehot = (bus.an != '0) && ((bus.an & (bus.an - NDIG'(1))) == '0);
    assign pair_same = (bus.an == prev_an_q) && (bus.SSeg == prev_seg_q);

    // Position of the active select bit.
    always_comb begin
        an_idx = '0;
        for (int k = 0; k < NDIG; k++) begin
            if (bus.an[k]) begin
                an_idx = IDX_W'(k);
            end
        end
    end

    // Segment pattern to BCD, including the tailed/untailed 6, 7 and 9 variants.
    always_comb begin
        pat_kind = PAT_DIGIT;
        pat_val  = 4'h0;
        case (bus.SSeg)
            7'b1111110: pat_val = 4'd0;
            7'b0110000: pat_val = 4'd1;
            7'b1101101: pat_val = 4'd2;
            7'b1111001: pat_val = 4'd3;
            7'b0110011: pat_val = 4'd4;
            7'b1011011: pat_val = 4'd5;
            7'b1011111: pat_val = 4'd6;
            7'b0011111: pat_val = 4'd6;
            7'b1110000: pat_val = 4'd7;
            7'b1110010: pat_val = 4'd7;
            7'b1111111: pat_val = 4'd8;
            7'b1111011: pat_val = 4'd9;
            7'b1110011: pat_val = 4'd9;
            7'b0000000: pat_kind = PAT_BLANK;
            default:    pat_kind = PAT_ILLEGAL;
        endcase
    end

    // A changed pair starts a fresh dwell if it is one-hot, otherwise falls back to idle.
    always_comb begin
        if (an_onehot) begin
            restart_state = ST_TRACK;
            restart_cnt   = CNT_W'(1);
        end else begin
            restart_state = ST_IDLE;
            restart_cnt   = '0;
        end
    end

    // Dwell-tracking next state; accept fires once when the count reaches STABLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d = restart_state;
                cnt_d   = restart_cnt;
            end
            ST_TRACK: begin
                if (pair_same && an_onehot) begin
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if ((cnt_q + CNT_W'(1)) == CNT_W'(STABLE)) begin
                        accept  = 1'b1;
                        state_d = ST_HELD;
                    end
                end else begin
                    state_d = restart_state;
                    cnt_d   = restart_cnt;
                end
            end
            ST_HELD: begin
                if (!pair_same) begin
                    state_d = restart_state;
                    cnt_d   = restart_cnt;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Digit capture: only the selected digit's fields change on an accept.
    always_comb begin
        bcd_d       = bcd_q;
        dig_valid_d = dig_valid_q;
        dig_err_d   = dig_err_q;
        upd_d       = accept;
        upd_idx_d   = upd_idx_q;
        if (accept) begin
            upd_idx_d = an_idx;
        end
        for (int k = 0; k < NDIG; k++) begin
            if (accept && (an_idx == IDX_W'(k))) begin
                case (pat_kind)
                    PAT_DIGIT: begin
                        bcd_d[4*k +: 4] = pat_val;
                        dig_valid_d[k]  = 1'b1;
                        dig_err_d[k]    = 1'b0;
                    end
                    PAT_BLANK: begin
                        bcd_d[4*k +: 4] = 4'hF;
                        dig_valid_d[k]  = 1'b0;
                        dig_err_d[k]    = 1'b0;
                    end
                    default: begin
                        dig_valid_d[k]  = 1'b0;
                        dig_err_d[k]    = 1'b1;
                    end
                endcase
            end
        end
    end

    // State, history and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            prev_an_q   <= '0;
            prev_seg_q  <= '0;
            bcd_q       <= '1;
            dig_valid_q <= '0;
            dig_err_q   <= '0;
            upd_q       <= 1'b0;
            upd_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            prev_an_q   <= bus.an;
            prev_seg_q  <= bus.SSeg;
            bcd_q       <= bcd_d;
            dig_valid_q <= dig_valid_d;
            dig_err_q   <= dig_err_d;
            upd_q       <= upd_d;
            upd_idx_q   <= upd_idx_d;
        end
    end

    assign bus.bcd       = bcd_q;
    assign bus.dig_valid = dig_valid_q;
    assign bus.dig_err   = dig_err_q;
    assign bus.upd       = upd_q;
    assign bus.upd_idx   = upd_idx_q;

endmodule

// File: tb/tb_sseg_capture.sv
// Testbench for sseg_capture: dwell-level stimulus with a scoreboard of expected accepts.
module tb_sseg_capture;

    localparam int unsigned NDIG   = 4;
    localparam int unsigned STABLE = 3;

    typedef struct {
        logic [2:0]  idx;
        logic [15:0] bcd;
        logic [3:0]  valid;
        logic [3:0]  err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sseg_capture_if #(.NDIG(NDIG)) bus ();

    sseg_capture #(.NDIG(NDIG), .STABLE(STABLE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int pushes = 0;
    int upd_seen = 0;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic        prev_upd = 1'b0;

    logic [15:0] m_bcd;
    logic [3:0]  m_valid;
    logic [3:0]  m_err;
    logic [3:0]  last_an;
    logic [6:0]  last_seg;
    int          run;

    // Reference decode: kind 0 = digit, 1 = blank, 2 = illegal.
    function automatic void ref_decode(input logic [6:0] s, output int kind, output logic [3:0] v);
        kind = 0;
        v    = 4'h0;
        case (s)
            7'h7E: v = 4'd0;
            7'h30: v = 4'd1;
            7'h6D: v = 4'd2;
            7'h79: v = 4'd3;
            7'h33: v = 4'd4;
            7'h5B: v = 4'd5;
            7'h5F, 7'h1F: v = 4'd6;
            7'h70, 7'h72: v = 4'd7;
            7'h7F: v = 4'd8;
            7'h7B, 7'h73: v = 4'd9;
            7'h00: kind = 1;
            default: kind = 2;
        endcase
    endfunction

    task automatic model_reset();
        m_bcd    = 16'hFFFF;
        m_valid  = 4'h0;
        m_err    = 4'h0;
        last_an  = 4'h0;
        last_seg = 7'h00;
        run      = 0;
        sb_q.delete();
        pushes   = upd_seen;
    endtask

    // Hold a pair for n rising edges; predicts and queues any accept it should cause.
    task automatic dwell(input logic [3:0] a, input logic [6:0] s, input int n);
        int         old;
        int         kind;
        int         k;
        logic [3:0] v;
        exp_t       e;
        bus.an   = a;
        bus.SSeg = s;
        old = (a == last_an && s == last_seg) ? run : 0;
        run      = old + n;
        last_an  = a;
        last_seg = s;
        if ($onehot(a) && old < int'(STABLE) && run >= int'(STABLE)) begin
            k = 0;
            for (int i = 0; i < 4; i++) if (a[i]) k = i;
            ref_decode(s, kind, v);
            if (kind == 0) begin
                m_bcd[4*k +: 4] = v;
                m_valid[k] = 1'b1;
                m_err[k]   = 1'b0;
            end else if (kind == 1) begin
                m_bcd[4*k +: 4] = 4'hF;
                m_valid[k] = 1'b0;
                m_err[k]   = 1'b0;
            end else begin
                m_valid[k] = 1'b0;
                m_err[k]   = 1'b1;
            end
            e.idx   = 3'(k);
            e.bcd   = m_bcd;
            e.valid = m_valid;
            e.err   = m_err;
            sb_q.push_back(e);
            pushes++;
        end
        repeat (n) @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    // Scoreboard consumer: every upd pulse must match the oldest queued accept.
    always @(negedge clk) begin
        if (rst) begin
            prev_upd = 1'b0;
        end else begin
            if (bus.upd) begin
                upd_seen++;
                checks++;
                if (prev_upd) begin
                    errors++;
                    $display("FAIL upd_back_to_back upd high on consecutive cycles idx=%0d", bus.upd_idx);
                end else if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_upd got idx=%0d bcd=%h required no update", bus.upd_idx, bus.bcd);
                end else begin
                    mon_e = sb_q.pop_front();
                    if (bus.upd_idx !== mon_e.idx || bus.bcd !== mon_e.bcd ||
                        bus.dig_valid !== mon_e.valid || bus.dig_err !== mon_e.err) begin
                        errors++;
                        $display("FAIL accept got idx=%0d bcd=%h valid=%b err=%b required idx=%0d bcd=%h valid=%b err=%b",
                                 bus.upd_idx, bus.bcd, bus.dig_valid, bus.dig_err,
                                 mon_e.idx, mon_e.bcd, mon_e.valid, mon_e.err);
                    end
                end
            end
            prev_upd = bus.upd;
        end
    end

    task automatic test_reset();
        rst      = 1'b1;
        bus.an   = 4'h0;
        bus.SSeg = 7'h00;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++; if (bus.bcd !== 16'hFFFF) begin errors++; $display("FAIL reset_bcd got %h required ffff", bus.bcd); end
        checks++; if (bus.dig_valid !== 4'h0) begin errors++; $display("FAIL reset_valid got %b required 0000", bus.dig_valid); end
        checks++; if (bus.dig_err !== 4'h0) begin errors++; $display("FAIL reset_err got %b required 0000", bus.dig_err); end
        checks++; if (bus.upd !== 1'b0) begin errors++; $display("FAIL reset_upd got %b required 0", bus.upd); end
        checks++; if (bus.upd_idx !== 3'd0) begin errors++; $display("FAIL reset_upd_idx got %0d required 0", bus.upd_idx); end
        rst = 1'b0;
    endtask

    task automatic check_state(input string name);
        checks++;
        if (bus.bcd !== m_bcd || bus.dig_valid !== m_valid || bus.dig_err !== m_err) begin
            errors++;
            $display("FAIL %s_state got bcd=%h valid=%b err=%b required bcd=%h valid=%b err=%b",
                     name, bus.bcd, bus.dig_valid, bus.dig_err, m_bcd, m_valid, m_err);
        end
        checks++;
        if (upd_seen != pushes || sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s_updates got %0d pulses required %0d (pending %0d)",
                     name, upd_seen, pushes, sb_q.size());
        end
    endtask

    task automatic test_single();
        dwell(4'b0001, 7'h79, 3);
        checks++; if (bus.bcd[3:0] !== 4'd3) begin errors++; $display("FAIL single_digit0 got %h required 3", bus.bcd[3:0]); end
        dwell(4'b0001, 7'h79, 10);
        check_state("single");
    endtask

    task automatic test_scan();
        dwell(4'b0001, 7'h33, 5);
        dwell(4'b0010, 7'h6D, 5);
        dwell(4'b0100, 7'h7E, 5);
        dwell(4'b1000, 7'h6D, 5);
        checks++; if (bus.bcd !== 16'h2024) begin errors++; $display("FAIL scan_bcd got %h required 2024", bus.bcd); end
        checks++; if (bus.dig_valid !== 4'b1111) begin errors++; $display("FAIL scan_valid got %b required 1111", bus.dig_valid); end
        check_state("scan");
    endtask

    task automatic test_illegal();
        dwell(4'b0100, 7'h49, 3);
        checks++; if (bus.dig_err !== 4'b0100) begin errors++; $display("FAIL illegal_err got %b required 0100", bus.dig_err); end
        checks++; if (bus.bcd[11:8] !== 4'd0) begin errors++; $display("FAIL illegal_keep got %h required 0", bus.bcd[11:8]); end
        dwell(4'b0100, 7'h72, 3);
        checks++; if (bus.bcd[11:8] !== 4'd7 || bus.dig_err[2] !== 1'b0) begin
            errors++; $display("FAIL illegal_recover got %h err=%b required 7 err=0", bus.bcd[11:8], bus.dig_err[2]);
        end
        check_state("illegal");
    endtask

    task automatic test_short();
        dwell(4'b0001, 7'h7E, 2);
        dwell(4'b0011, 7'h7E, 6);
        dwell(4'b0000, 7'h7F, 4);
        check_state("short");
    endtask

    task automatic test_blank();
        dwell(4'b0010, 7'h5B, 5);
        checks++; if (bus.bcd[7:4] !== 4'd5) begin errors++; $display("FAIL blank_pre got %h required 5", bus.bcd[7:4]); end
        dwell(4'b0010, 7'h00, 3);
        checks++; if (bus.bcd[7:4] !== 4'hF || bus.dig_valid[1] !== 1'b0) begin
            errors++; $display("FAIL blank_digit got %h valid=%b required f valid=0", bus.bcd[7:4], bus.dig_valid[1]);
        end
        check_state("blank");
    endtask

    task automatic test_back_to_back();
        dwell(4'b0001, 7'h1F, 3);
        dwell(4'b0010, 7'h73, 3);
        dwell(4'b0001, 7'h1F, 3);
        dwell(4'b1000, 7'h70, 3);
        dwell(4'b1000, 7'h7E, 2);
        dwell(4'b1000, 7'h7F, 1);
        dwell(4'b1000, 7'h7E, 3);
        dwell(4'b0100, 7'h30, 4);
        dwell(4'b0100, 7'h7B, 2);
        dwell(4'b0010, 7'h7B, 3);
        check_state("b2b");
    endtask

    task automatic test_reset_mid();
        dwell(4'b0001, 7'h79, 1);
        rst = 1'b1;
        #1;
        checks++; if (bus.bcd !== 16'hFFFF || bus.dig_valid !== 4'h0 || bus.dig_err !== 4'h0 ||
                      bus.upd !== 1'b0 || bus.upd_idx !== 3'd0) begin
            errors++; $display("FAIL midreset got bcd=%h valid=%b err=%b upd=%b idx=%0d required reset values",
                               bus.bcd, bus.dig_valid, bus.dig_err, bus.upd, bus.upd_idx);
        end
        model_reset();
        @(negedge clk);
        #1;
        rst = 1'b0;
        dwell(4'b0001, 7'h79, 3);
        checks++; if (bus.bcd !== 16'hFFF3 || bus.dig_valid !== 4'b0001) begin
            errors++; $display("FAIL midreset_recover got bcd=%h valid=%b required fff3 0001", bus.bcd, bus.dig_valid);
        end
        check_state("midreset");
    endtask

    initial begin
        test_reset();
        test_single();
        test_scan();
        test_illegal();
        test_short();
        test_blank();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
